// File: rtl/axi_bresp_return.sv
// axi_bresp_return: write-response return path for one master-side port.
// Round-robin arbitrates B responses from N_INIT_PORT slave-side sources into
// a single registered B channel, counts outstanding writes for the AW decoder
// and injects DECERR responses for writes that decoded to no slave.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   bvalid_i/bid_i/...     per-source B channel (source k at slice k*W +: W)
//   bready_o               one-hot accept to the granted source
//   bvalid_o/bid_o/...     registered B channel toward the master
//   bready_i               master ready
//   incr_req_i             one write issued to a slave
//   full_counter_o         outstanding count at MAX_OUTSTANDING
//   outstanding_trans_o    outstanding count non-zero
//   error_req_i/_id_i/_user_i  DECERR injection request and its BID/BUSER
//   error_gnt_o            DECERR accepted this cycle
module axi_bresp_return #(
   parameter int unsigned N_INIT_PORT     = 8,
   parameter int unsigned AXI_ID          = 6,
   parameter int unsigned AXI_USER        = 6,
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned CNT_WIDTH       = 5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_INIT_PORT-1:0]          bvalid_i,
   input  logic [N_INIT_PORT*AXI_ID-1:0]   bid_i,
   input  logic [N_INIT_PORT*2-1:0]        bresp_i,
   input  logic [N_INIT_PORT*AXI_USER-1:0] buser_i,
   output logic [N_INIT_PORT-1:0]          bready_o,
   output logic                            bvalid_o,
   output logic [AXI_ID-1:0]               bid_o,
   output logic [1:0]                      bresp_o,
   output logic [AXI_USER-1:0]             buser_o,
   input  logic                            bready_i,
   input  logic                            incr_req_i,
   output logic                            full_counter_o,
   output logic                            outstanding_trans_o,
   input  logic                            error_req_i,
   input  logic [AXI_ID-1:0]               error_id_i,
   input  logic [AXI_USER-1:0]             error_user_i,
   output logic                            error_gnt_o
);

   localparam int unsigned IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
   localparam logic [1:0]  DECERR = 2'b11;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   out_state_e            state_q;
   logic [AXI_ID-1:0]     bid_q;
   logic [1:0]            bresp_q;
   logic [AXI_USER-1:0]   buser_q;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  load_en;
   logic                  err_load;
   logic                  slv_load;
   logic                  slv_hs;
   logic                  gnt_found;
   logic [IDX_W-1:0]      gnt_idx;
   logic [IDX_W-1:0]      cand;
   logic [AXI_ID-1:0]     sel_bid;
   logic [1:0]            sel_bresp;
   logic [AXI_USER-1:0]   sel_buser;

   // Output register can take a new beat when empty or draining this cycle;
   // bready_i is only consulted when full.
   assign load_en  = (state_q == OUT_EMPTY) | (bready_i & (state_q == OUT_FULL));
   assign err_load = load_en & error_req_i;
   assign slv_load = load_en & ~error_req_i & gnt_found;

   // Round-robin search: first valid source at or above rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned off = 0; off < N_INIT_PORT; off++) begin
         cand = IDX_W'((32'(rr_ptr_q) + off) % N_INIT_PORT);
         if (!gnt_found && bvalid_i[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Payload of the granted source.
   always_comb begin
      sel_bid   = '0;
      sel_bresp = '0;
      sel_buser = '0;
      for (int unsigned k = 0; k < N_INIT_PORT; k++) begin
         if (gnt_idx == IDX_W'(k)) begin
            sel_bid   = bid_i[k*AXI_ID +: AXI_ID];
            sel_bresp = bresp_i[k*2 +: 2];
            sel_buser = buser_i[k*AXI_USER +: AXI_USER];
         end
      end
   end

   // One-hot accept to the granted source.
   always_comb begin
      bready_o = '0;
      if (slv_load) bready_o[gnt_idx] = 1'b1;
   end

   assign error_gnt_o = err_load;
   assign slv_hs      = |(bvalid_i & bready_o);

   // Outstanding counter, saturating at both ends; DECERR beats excluded.
   always_comb begin
      cnt_d = cnt_q;
      if (incr_req_i && !slv_hs && (32'(cnt_q) < MAX_OUTSTANDING)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (!incr_req_i && slv_hs && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   // Pointer moves past the granted source; error grants leave it alone.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (slv_load) begin
         rr_ptr_d = (gnt_idx == IDX_W'(N_INIT_PORT - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   // Output register FSM, payload, pointer and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OUT_EMPTY;
         bid_q    <= '0;
         bresp_q  <= '0;
         buser_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         if (err_load) begin
            state_q <= OUT_FULL;
            bid_q   <= error_id_i;
            bresp_q <= DECERR;
            buser_q <= error_user_i;
         end else if (slv_load) begin
            state_q <= OUT_FULL;
            bid_q   <= sel_bid;
            bresp_q <= sel_bresp;
            buser_q <= sel_buser;
         end else if (load_en) begin
            state_q <= OUT_EMPTY;
         end
      end
   end

   assign bvalid_o            = (state_q == OUT_FULL);
   assign bid_o               = bid_q;
   assign bresp_o             = bresp_q;
   assign buser_o             = buser_q;
   assign full_counter_o      = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
   assign outstanding_trans_o = (cnt_q != '0);

endmodule

// File: tb/tb_axi_bresp_return.sv
// Testbench for axi_bresp_return: table of hand-derived cycle vectors,
// directed corner sequences and random traffic against a reference model.
module tb_axi_bresp_return;

   localparam int N   = 8;
   localparam int IDW = 6;
   localparam int USW = 6;
   localparam int MAXO = 16;

   logic                 clk;
   logic                 rst_n;
   logic [N-1:0]         bv;
   logic [N*IDW-1:0]     bid_i;
   logic [N*2-1:0]       bresp_i;
   logic [N*USW-1:0]     buser_i;
   logic [N-1:0]         bready_o;
   logic                 bvalid_o;
   logic [IDW-1:0]       bid_o;
   logic [1:0]           bresp_o;
   logic [USW-1:0]       buser_o;
   logic                 rdy;
   logic                 incr;
   logic                 full_counter_o;
   logic                 outstanding_trans_o;
   logic                 err;
   logic [IDW-1:0]       eid;
   logic [USW-1:0]       euser;
   logic                 error_gnt_o;

   logic [IDW-1:0]       src_id   [N];
   logic [1:0]           src_resp [N];
   logic [USW-1:0]       src_user [N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign bid_i[g*IDW +: IDW]   = src_id[g];
      assign bresp_i[g*2 +: 2]     = src_resp[g];
      assign buser_i[g*USW +: USW] = src_user[g];
   end

   axi_bresp_return #(
      .N_INIT_PORT(N), .AXI_ID(IDW), .AXI_USER(USW),
      .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(5)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .bvalid_i(bv), .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i),
      .bready_o(bready_o), .bvalid_o(bvalid_o), .bid_o(bid_o),
      .bresp_o(bresp_o), .buser_o(buser_o), .bready_i(rdy),
      .incr_req_i(incr), .full_counter_o(full_counter_o),
      .outstanding_trans_o(outstanding_trans_o),
      .error_req_i(err), .error_id_i(eid), .error_user_i(euser),
      .error_gnt_o(error_gnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: what the master sees and what is pending.
   bit              m_full;
   logic [IDW-1:0]  m_bid;
   logic [1:0]      m_bresp;
   logic [USW-1:0]  m_buser;
   int              m_ptr;
   int              m_cnt;

   logic [N-1:0]    last_brdy;
   logic            last_egnt;
   logic            last_bv;
   logic [IDW-1:0]  last_bid;

   typedef struct packed {
      logic          incr;
      logic [N-1:0]  bv;
      logic          rdy;
      logic          err;
      logic [N-1:0]  e_brdy;
      logic          e_egnt;
      logic          e_bv;
      logic [IDW-1:0] e_bid;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 0; m_bid = '0; m_bresp = '0; m_buser = '0; m_ptr = 0; m_cnt = 0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".bvalid_o"}, bvalid_o, 0);
      chk({tag, ".bid_o"}, bid_o, 0);
      chk({tag, ".bresp_o"}, bresp_o, 0);
      chk({tag, ".buser_o"}, buser_o, 0);
      chk({tag, ".bready_o"}, bready_o, 0);
      chk({tag, ".error_gnt_o"}, error_gnt_o, 0);
      chk({tag, ".full_counter_o"}, full_counter_o, 0);
      chk({tag, ".outstanding_o"}, outstanding_trans_o, 0);
   endtask

   // Called just after a falling edge with inputs applied: check all outputs
   // against the model, advance the model over the rising edge, and return
   // at the next falling edge.
   task automatic step();
      bit           load;
      bit           egnt;
      int           g;
      logic [N-1:0] ebr;
      #1;
      load = !m_full || rdy;
      egnt = load && err;
      g = -1;
      if (load && !err) begin
         for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (g < 0 && bv[k]) g = k;
         end
      end
      ebr = (g >= 0) ? N'(1 << g) : '0;
      chk("bready_o", bready_o, ebr);
      chk("error_gnt_o", error_gnt_o, egnt);
      chk("bvalid_o", bvalid_o, m_full);
      if (m_full) begin
         chk("bid_o", bid_o, m_bid);
         chk("bresp_o", bresp_o, m_bresp);
         chk("buser_o", buser_o, m_buser);
      end
      chk("full_counter_o", full_counter_o, m_cnt == MAXO);
      chk("outstanding_o", outstanding_trans_o, m_cnt != 0);
      last_brdy = bready_o;
      last_egnt = error_gnt_o;
      last_bv   = bvalid_o;
      last_bid  = bid_o;
      if (incr && g < 0 && m_cnt < MAXO) m_cnt++;
      else if (!incr && g >= 0 && m_cnt > 0) m_cnt--;
      if (egnt) begin
         m_full = 1; m_bid = eid; m_bresp = 2'b11; m_buser = euser;
      end else if (g >= 0) begin
         m_full = 1; m_bid = src_id[g]; m_bresp = src_resp[g]; m_buser = src_user[g];
         m_ptr = (g + 1) % N;
      end else if (load) begin
         m_full = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bv = '0; rdy = 1'b0; incr = 1'b0; err = 1'b0;
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0;
      idle_inputs();
      eid = 6'h2A; euser = 6'h15;
      for (int k = 0; k < N; k++) begin
         src_id[k]   = IDW'(8'h10 + k);
         src_resp[k] = 2'(k);
         src_user[k] = USW'(8'h20 + k);
      end
      model_reset();

      tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'h00};
      for (int i = 1; i < 6; i++) tbl[i] = tbl[0];
      tbl[6]  = '{1'b0, 8'h85, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 6'h00};
      tbl[7]  = '{1'b0, 8'h85, 1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 6'h10};
      tbl[8]  = '{1'b0, 8'h85, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 6'h12};
      tbl[9]  = '{1'b0, 8'h85, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'h17};
      tbl[10] = tbl[9];
      tbl[11] = '{1'b0, 8'h85, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 6'h17};
      tbl[12] = '{1'b0, 8'h85, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 6'h10};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'h2A};
      tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 6'h2A};
      tbl[15] = '{1'b0, 8'h04, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 6'h00};
      tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'h12};

      // Reset values
      repeat (3) @(negedge clk);
      #1 chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Vector table: round robin 0,2,7,0, stall, DECERR, drain, pointer kept
      for (int i = 0; i < 17; i++) begin
         incr = tbl[i].incr; bv = tbl[i].bv; rdy = tbl[i].rdy; err = tbl[i].err;
         step();
         chk($sformatf("tbl[%0d].bready", i), last_brdy, tbl[i].e_brdy);
         chk($sformatf("tbl[%0d].egnt", i), last_egnt, tbl[i].e_egnt);
         chk($sformatf("tbl[%0d].bvalid", i), last_bv, tbl[i].e_bv);
         if (tbl[i].e_bv) chk($sformatf("tbl[%0d].bid", i), last_bid, tbl[i].e_bid);
      end

      // Single response from source 3
      idle_inputs(); rdy = 1'b1;
      step();
      src_id[3] = 6'h15; src_resp[3] = 2'b00;
      bv = 8'h08;
      step();
      chk("single.bready", last_brdy, 8'h08);
      bv = 8'h00;
      #1;
      chk("single.bvalid", bvalid_o, 1);
      chk("single.bid", bid_o, 6'h15);
      chk("single.cnt_zero", outstanding_trans_o, 0);
      step();

      // Backpressure: source 1 held valid, master stalls 5 cycles
      idle_inputs(); incr = 1'b1;
      repeat (3) step();
      incr = 1'b0; bv = 8'h02; rdy = 1'b0;
      pulses = 0;
      repeat (6) begin
         step();
         if (last_brdy != '0) pulses++;
      end
      chk("bp.pulses", 64'(pulses), 1);
      chk("bp.bid_stable", bid_o, src_id[1]);
      rdy = 1'b1;
      step();
      chk("bp.regrant", last_brdy, 8'h02);
      bv = 8'h00;
      step();

      // Reset while full and stalled
      idle_inputs(); incr = 1'b1; step();
      incr = 1'b0; bv = 8'h02; step();
      bv = 8'h00; step();
      chk("rst_pre.bvalid", bvalid_o, 1);
      idle_inputs();
      rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // DECERR with nothing outstanding
      err = 1'b1; rdy = 1'b1; eid = 6'h2A; euser = 6'h15;
      step();
      chk("decerr.gnt", last_egnt, 1);
      err = 1'b0;
      #1;
      chk("decerr.bresp", bresp_o, 2'b11);
      chk("decerr.bid", bid_o, 6'h2A);
      chk("decerr.cnt", outstanding_trans_o, 0);
      step();
      chk("decerr.pulse", last_egnt, 0);

      // Counter: fill to the limit, balanced cycle, then one drain
      idle_inputs(); rdy = 1'b1; incr = 1'b1;
      repeat (16) step();
      chk("cnt.full", full_counter_o, 1);
      bv = 8'h02;
      step();
      chk("cnt.both_full", full_counter_o, 1);
      incr = 1'b0;
      step();
      chk("cnt.drain", full_counter_o, 0);
      bv = 8'h00;
      step();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         incr  = (m_cnt < MAXO - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         bv    = (m_cnt > 0) ? N'($urandom) : '0;
         rdy   = ($urandom_range(0, 3) != 0);
         err   = ($urandom_range(0, 7) == 0);
         eid   = IDW'($urandom);
         euser = USW'($urandom);
         for (int k = 0; k < N; k++) begin
            src_id[k]   = IDW'($urandom);
            src_resp[k] = 2'($urandom);
            src_user[k] = USW'($urandom);
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/axi_bresp_return.md
# axi_bresp_return

Write-response return path for one target (master-side) port of the AXI node. It runs in the opposite direction to the AW address decoder. It round-robin arbitrates the B responses arriving from N_INIT_PORT initiator (slave-side) ports into a single registered B channel toward the master. It tracks outstanding writes for the decoder, and on the decoder's request it injects a DECERR response for writes that decoded to no slave.

## Interface
Parameters:
- N_INIT_PORT, 8, number of slave-side B sources
- AXI_ID, 6, BID width
- AXI_USER, 6, BUSER width
- MAX_OUTSTANDING, 16, outstanding-write limit
- CNT_WIDTH, 5, counter width; must satisfy 2^CNT_WIDTH > MAX_OUTSTANDING

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bvalid_i  in  N_INIT_PORT  per-source response valid
- bid_i  in  N_INIT_PORT*AXI_ID  per-source BID; source k occupies slice [k*AXI_ID +: AXI_ID]
- bresp_i  in  N_INIT_PORT*2  per-source BRESP
- buser_i  in  N_INIT_PORT*AXI_USER  per-source BUSER
- bready_o  out  N_INIT_PORT  one-hot accept to the granted source
- bvalid_o  out  1  response valid to master
- bid_o  out  AXI_ID  BID to master
- bresp_o  out  2  BRESP to master
- buser_o  out  AXI_USER  BUSER to master
- bready_i  in  1  master ready
- incr_req_i  in  1  decoder pulse: one write issued to a slave
- full_counter_o  out  1  outstanding count == MAX_OUTSTANDING
- outstanding_trans_o  out  1  outstanding count != 0
- error_req_i  in  1  decoder requests DECERR injection
- error_id_i  in  AXI_ID  BID for the DECERR response
- error_user_i  in  AXI_USER  BUSER for the DECERR response
- error_gnt_o  out  1  DECERR accepted (one-cycle pulse)

## Operation
- Output register FSM has two states.
  - OUT_EMPTY: bvalid_o=0.
  - OUT_FULL: bvalid_o=1; holds bid_o, bresp_o and buser_o stable.
- load_en = (state==OUT_EMPTY) | (bready_i & bvalid_o).
- Error injection has priority over slave sources.
  - Condition: load_en & error_req_i.
  - Action: load bid_o=error_id_i, bresp_o=2'b11, buser_o=error_user_i; assert error_gnt_o; all bready_o=0; go to OUT_FULL.
- Slave arbitration (load_en & ~error_req_i & |bvalid_i):
  - Grant the first valid source scanning from rr_ptr upward, wrapping at N_INIT_PORT-1 -> 0.
  - bready_o[g]=1 combinationally, one-hot.
  - Load that source's bid/bresp/buser; go to OUT_FULL.
  - rr_ptr <= (g+1) mod N_INIT_PORT.
- If load_en and nothing is loaded: a master handshake returns the FSM to OUT_EMPTY; otherwise the state is unchanged.
- bready_o=0 for every source whenever load_en=0.
- Outstanding counter cnt:
  - +1 on incr_req_i.
  - -1 on a slave handshake (|(bvalid_i & bready_o)).
  - Both in the same cycle: unchanged.
  - Saturates at MAX_OUTSTANDING and at 0; these cases are protocol violations and must not occur.
  - DECERR responses do not touch cnt.
- rr_ptr does not change on an error grant.

## Timing
- Reset values: bvalid_o=0, bid_o=0, bresp_o=0, buser_o=0, bready_o=0, error_gnt_o=0, full_counter_o=0, outstanding_trans_o=0; cnt=0, rr_ptr=0, state OUT_EMPTY.
- Latency: a source handshake in cycle t gives bvalid_o=1 in cycle t+1.
- Throughput: one response per cycle when bready_i is held high.
- bvalid_o never drops without bready_i; the payload is stable while stalled (AXI rule).
- bready_o and error_gnt_o are combinational from registered state, bvalid_i, error_req_i and bready_i. They have no combinational path from bready_i when state==OUT_EMPTY.
- full_counter_o and outstanding_trans_o are decoded from registered cnt and reflect an update one cycle after the event.
- Reset mid-transfer discards the output register content immediately (asynchronous reset).

## Test plan
- Single response: source 3 asserts bvalid with bid=0x15, bresp=0; bready_i=1. Required: bready_o=0x08 in cycle 0; bvalid_o=1 with bid_o=0x15 in cycle 1; cnt decrements.
- Round-robin: sources 0, 2 and 7 held valid continuously with bready_i=1. Required: grants follow 0,2,7,0,2,7 with one response per cycle.
- Backpressure: bready_i=0 for 5 cycles with source 1 valid. Required: bvalid_o stays 1 with a stable payload; only one bready_o pulse occurs; the next grant comes in the same cycle as the master handshake.
- DECERR: cnt=0, error_req_i=1, error_id_i=0x2A. Required: one-cycle error_gnt_o pulse; next cycle bresp_o=2'b11, bid_o=0x2A; cnt stays 0.
- Counter: 16 incr_req_i pulses give full_counter_o=1. Then a simultaneous incr and slave handshake leaves it at 16; one more slave handshake alone gives full_counter_o=0.
- Reset asserted while OUT_FULL and stalled: bvalid_o=0 immediately; all outputs at their reset values.
